// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter: single-port memory arbiter between instruction fetch (IFU)
// and execute (EXEC). Request pulses are captured into one-entry slots, one
// access is issued per cycle from registers, and read data is steered back to
// the requester that issued the read.
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_rd_vld,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_busy,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_rd_vld,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  proto_err
);

  // Read-owner tag encodings
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_EXEC = 2'd2;

  // Request slots
  logic                  r_ifu_pend;
  logic [ADDR_WIDTH-1:0] r_ifu_addr;
  logic                  r_ex_pend;
  logic                  r_ex_we;
  logic [ADDR_WIDTH-1:0] r_ex_addr;
  logic [DATA_WIDTH-1:0] r_ex_wdata;

  // Round-robin pointer: 1 = IFU has priority, 0 = EXEC has priority
  logic                  r_rr_ifu;

  // Issue stage and read-return tracking
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [1:0]            r_iss_owner;
  logic [1:0]            r_rd_owner;
  logic                  r_err;

  // Combinational arbitration results
  logic                  w_raw;
  logic                  w_grant_ifu;
  logic                  w_grant_ex;
  logic                  w_rr_flip;
  logic                  w_ex_req;
  logic                  w_err_evt;

  assign w_ex_req  = exec_rd_req | exec_wr_req;
  assign w_err_evt = (exec_rd_req & exec_wr_req)
                   | (ifu_rd_req & r_ifu_pend)
                   | (w_ex_req & r_ex_pend);

  // Pick one pending slot: RAW hazard forces EXEC, otherwise round-robin on contention
  always_comb begin
    w_raw       = r_ex_pend & r_ex_we & r_ifu_pend & (r_ex_addr == r_ifu_addr);
    w_grant_ifu = 1'b0;
    w_grant_ex  = 1'b0;
    w_rr_flip   = 1'b0;
    if (r_ifu_pend && r_ex_pend) begin
      if (w_raw) begin
        w_grant_ex = 1'b1;
      end else begin
        w_rr_flip = 1'b1;
        if (r_rr_ifu) w_grant_ifu = 1'b1;
        else          w_grant_ex  = 1'b1;
      end
    end else begin
      w_grant_ifu = r_ifu_pend;
      w_grant_ex  = r_ex_pend;
    end
  end

  // Slot capture/release and round-robin pointer update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ifu_pend <= 1'b0;
      r_ifu_addr <= '0;
      r_ex_pend  <= 1'b0;
      r_ex_we    <= 1'b0;
      r_ex_addr  <= '0;
      r_ex_wdata <= '0;
      r_rr_ifu   <= 1'b0;
    end else begin
      if (w_grant_ifu) begin
        r_ifu_pend <= 1'b0;
      end else if (ifu_rd_req && !r_ifu_pend) begin
        r_ifu_pend <= 1'b1;
        r_ifu_addr <= ifu_rd_addr;
      end
      // A simultaneous read+write keeps the write; the read is dropped
      if (w_grant_ex) begin
        r_ex_pend <= 1'b0;
      end else if (w_ex_req && !r_ex_pend) begin
        r_ex_pend  <= 1'b1;
        r_ex_we    <= exec_wr_req;
        r_ex_addr  <= exec_wr_req ? exec_wr_addr : exec_rd_addr;
        r_ex_wdata <= exec_wr_data;
      end
      if (w_rr_flip) r_rr_ifu <= ~r_rr_ifu;
    end
  end

  // Registered memory strobe driven from the granted slot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_iss_owner <= OWN_NONE;
    end else begin
      r_mem_req <= w_grant_ifu | w_grant_ex;
      if (w_grant_ex) begin
        r_mem_we    <= r_ex_we;
        r_mem_addr  <= r_ex_addr;
        r_mem_wdata <= r_ex_wdata;
        r_iss_owner <= r_ex_we ? OWN_NONE : OWN_EXEC;
      end else if (w_grant_ifu) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= r_ifu_addr;
        r_iss_owner <= OWN_IFU;
      end else begin
        r_iss_owner <= OWN_NONE;
      end
    end
  end

  // Owner tag for the read returning this cycle (memory latency is one cycle)
  always_ff @(posedge clk) begin
    if (!reset_n) r_rd_owner <= OWN_NONE;
    else          r_rd_owner <= r_iss_owner;
  end

  // Sticky protocol-violation flag
  always_ff @(posedge clk) begin
    if (!reset_n)       r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign ifu_busy     = r_ifu_pend;
  assign exec_busy    = r_ex_pend;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign ifu_rd_vld   = (r_rd_owner == OWN_IFU);
  assign exec_rd_vld  = (r_rd_owner == OWN_EXEC);
  assign ifu_rd_data  = mem_rdata;
  assign exec_rd_data = mem_rdata;
  assign proto_err    = r_err;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Self-checking bench for pdp_mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_pdp_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ifu_rd_req;
  logic [AW-1:0] ifu_rd_addr;
  logic          ifu_rd_vld;
  logic [DW-1:0] ifu_rd_data;
  logic          ifu_busy;
  logic          exec_rd_req;
  logic [AW-1:0] exec_rd_addr;
  logic          exec_wr_req;
  logic [AW-1:0] exec_wr_addr;
  logic [DW-1:0] exec_wr_data;
  logic          exec_rd_vld;
  logic [DW-1:0] exec_rd_data;
  logic          exec_busy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          proto_err;

  always #5 clk = ~clk;

  pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_vld(ifu_rd_vld), .ifu_rd_data(ifu_rd_data), .ifu_busy(ifu_busy),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_rd_vld(exec_rd_vld), .exec_rd_data(exec_rd_data), .exec_busy(exec_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  // Background contents for locations never written
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 12'o200) return 12'o7402;
    return DW'((32'(a) * 7) ^ 32'o1234);
  endfunction

  // Memory behind the arbiter: one-cycle read latency
  logic [DW-1:0] tb_mem [4096];
  bit            tb_wr  [4096];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        tb_mem[mem_addr] <= mem_wdata;
        tb_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: slot contents, arbitration pointer, issued access and returning read
  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } slot_t;

  slot_t         m_ifu, m_ex;
  bit            m_rr_ifu, m_err, m_rst;
  bit            m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_who;          // 0 none, 1 IFU, 2 EXEC
  bit            m_ifu_vld, m_ex_vld;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [4096];
  bit            ref_wr  [4096];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_ifu = '0; m_ex = '0; m_rr_ifu = 0; m_err = 0;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_who = 0;
    m_ifu_vld = 0; m_ex_vld = 0; m_rst = 1;
  endtask

  // Advance the model by one clock given the inputs held across that edge
  task automatic model_step(input logic rst_n, input logic ir, input logic [AW-1:0] ia,
                            input logic er, input logic [AW-1:0] ea, input logic ew,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int   win;
    logic cap_i, cap_e;
    if (m_req && m_we) begin
      ref_mem[m_addr] = m_wdata;
      ref_wr[m_addr]  = 1'b1;
    end
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_rst     = 0;
    m_ifu_vld = m_req && !m_we && m_who == 1;
    m_ex_vld  = m_req && !m_we && m_who == 2;
    if (m_req && !m_we) m_rdata = ref_rd(m_addr);
    win = 0;
    if (m_ifu.v && m_ex.v) begin
      if (m_ex.we && m_ex.a == m_ifu.a) win = 2;
      else begin
        win = m_rr_ifu ? 1 : 2;
        m_rr_ifu = !m_rr_ifu;
      end
    end else if (m_ifu.v) win = 1;
    else if (m_ex.v) win = 2;
    m_req = (win != 0);
    m_who = win;
    if (win == 1) begin m_we = 0; m_addr = m_ifu.a; end
    if (win == 2) begin m_we = m_ex.we; m_addr = m_ex.a; m_wdata = m_ex.d; end
    cap_i = ir && !m_ifu.v;
    cap_e = (er || ew) && !m_ex.v;
    if ((ir && m_ifu.v) || ((er || ew) && m_ex.v) || (er && ew)) m_err = 1;
    if (win == 1) m_ifu.v = 0;
    if (win == 2) m_ex.v = 0;
    if (cap_i) m_ifu = {1'b1, 1'b0, ia, 12'd0};
    if (cap_e) m_ex = ew ? {1'b1, 1'b1, wa, wd} : {1'b1, 1'b0, ea, 12'd0};
  endtask

  // Compare current outputs, apply the next inputs, then step one clock
  task automatic cyc(input logic rst_n, input logic ir, input logic [AW-1:0] ia,
                     input logic er, input logic [AW-1:0] ea, input logic ew,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    check("mem_req", 32'(mem_req), 32'(m_req));
    check("ifu_busy", 32'(ifu_busy), 32'(m_ifu.v));
    check("exec_busy", 32'(exec_busy), 32'(m_ex.v));
    check("proto_err", 32'(proto_err), 32'(m_err));
    check("ifu_rd_vld", 32'(ifu_rd_vld), 32'(m_ifu_vld));
    check("exec_rd_vld", 32'(exec_rd_vld), 32'(m_ex_vld));
    if (m_req || m_rst) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
    end
    if ((m_req && m_we) || m_rst) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    if (m_ifu_vld || m_ex_vld) begin
      check("ifu_rd_data", 32'(ifu_rd_data), 32'(m_rdata));
      check("exec_rd_data", 32'(exec_rd_data), 32'(m_rdata));
    end
    reset_n = rst_n; ifu_rd_req = ir; ifu_rd_addr = ia;
    exec_rd_req = er; exec_rd_addr = ea;
    exec_wr_req = ew; exec_wr_addr = wa; exec_wr_data = wd;
    model_step(rst_n, ir, ia, er, ea, ew, wa, wd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic          ir, er, ew, rst;
    logic [AW-1:0] ia, ea, wa;
    logic [DW-1:0] wd;
    int            k;

    reset_n = 1'b0; ifu_rd_req = 1'b0; ifu_rd_addr = '0;
    exec_rd_req = 1'b0; exec_rd_addr = '0;
    exec_wr_req = 1'b0; exec_wr_addr = '0; exec_wr_data = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Single IFU read of 0o200
    cyc(1'b1, 1'b1, 12'o200, 1'b0, '0, 1'b0, '0, '0);
    idle(4);

    // Contention straight after reset: EXEC first, then IFU first on the repeat
    do_reset();
    cyc(1'b1, 1'b1, 12'o100, 1'b1, 12'o300, 1'b0, '0, '0);
    idle(4);
    cyc(1'b1, 1'b1, 12'o100, 1'b1, 12'o300, 1'b0, '0, '0);
    idle(4);

    // Move pointer to IFU, then RAW write/read to 0o250 overrides it
    cyc(1'b1, 1'b1, 12'o101, 1'b1, 12'o301, 1'b0, '0, '0);
    idle(4);
    cyc(1'b1, 1'b1, 12'o250, 1'b0, '0, 1'b1, 12'o250, 12'o4321);
    idle(4);
    cyc(1'b1, 1'b1, 12'o102, 1'b1, 12'o302, 1'b0, '0, '0);
    idle(4);

    // Simultaneous EXEC read and write: write kept, sticky error until reset
    cyc(1'b1, 1'b0, '0, 1'b1, 12'o11, 1'b1, 12'o22, 12'o33);
    idle(6);
    do_reset();
    idle(2);

    // Second IFU request while busy is dropped with an error
    cyc(1'b1, 1'b1, 12'o40, 1'b0, '0, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 12'o41, 1'b0, '0, 1'b0, '0, '0);
    idle(4);
    do_reset();
    // Request in the cycle after grant is accepted cleanly
    cyc(1'b1, 1'b1, 12'o42, 1'b0, '0, 1'b0, '0, '0);
    idle(1);
    cyc(1'b1, 1'b1, 12'o43, 1'b0, '0, 1'b0, '0, '0);
    idle(4);

    // Reset in the cycle a read issues: no read-valid afterwards
    cyc(1'b1, 1'b1, 12'o60, 1'b0, '0, 1'b0, '0, '0);
    idle(1);
    do_reset();
    idle(3);

    // Randomized traffic with occasional protocol violations and resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      ir  = ($urandom_range(0, 2) == 0) && (!m_ifu.v || $urandom_range(0, 15) == 0);
      k   = $urandom_range(0, 5);
      er  = 1'b0;
      ew  = 1'b0;
      if (!m_ex.v || $urandom_range(0, 15) == 0) begin
        if (k == 0) er = 1'b1;
        if (k == 1) ew = 1'b1;
        if (k == 2 && $urandom_range(0, 15) == 0) begin er = 1'b1; ew = 1'b1; end
      end
      ia = AW'($urandom_range(0, 7));
      ea = AW'($urandom_range(0, 7));
      wa = AW'($urandom_range(0, 7));
      wd = DW'($urandom);
      cyc(rst, ir, ia, er, ea, ew, wa, wd);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pdp_mem_arbiter.md
# pdp_mem_arbiter

Single-port memory arbiter between the instruction fetch/decode path and the execution unit. It sits in front of memory_pdp. Single-cycle request pulses from each requester are captured into one-entry pending slots, and at most one memory access is issued per cycle. Read data is steered back to the requester that issued the read.

## Interface
- ADDR_WIDTH, 12, memory address width (`ADDR_WIDTH)
- DATA_WIDTH, 12, memory data width (`DATA_WIDTH)
- clk  in  1  free-running clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk
- ifu_rd_req  in  1  fetch read request, one-cycle pulse
- ifu_rd_addr  in  ADDR_WIDTH  fetch read address, valid with ifu_rd_req
- ifu_rd_vld  out  1  fetch read data valid, one-cycle pulse
- ifu_rd_data  out  DATA_WIDTH  fetch read data, meaningful only with ifu_rd_vld
- ifu_busy  out  1  fetch slot occupied; a new ifu_rd_req is not allowed
- exec_rd_req  in  1  execute read request, one-cycle pulse
- exec_rd_addr  in  ADDR_WIDTH  execute read address
- exec_wr_req  in  1  execute write request, one-cycle pulse
- exec_wr_addr  in  ADDR_WIDTH  execute write address
- exec_wr_data  in  DATA_WIDTH  execute write data
- exec_rd_vld  out  1  execute read data valid, one-cycle pulse
- exec_rd_data  out  DATA_WIDTH  execute read data
- exec_busy  out  1  execute slot occupied
- mem_req  out  1  memory access strobe
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read mem_req
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Slots: one IFU slot (read only) and one EXEC slot (read or write, plus a we bit). Each slot is EMPTY or PENDING.
- Capture: a request pulse seen with its slot EMPTY is latched into the slot, and the slot goes PENDING.
- busy: *_busy = slot PENDING.
- Arbitration: each cycle, if one or more slots are PENDING, exactly one is granted.
  - The granted slot drives mem_req/mem_we/mem_addr/mem_wdata from registers in the next cycle.
  - The granted slot returns to EMPTY in that same cycle.
- Contention policy: round-robin pointer rr. rr = EXEC after reset. When both slots are PENDING, the slot named by rr wins and rr flips to the other slot. With a single PENDING slot, that slot wins and rr is unchanged.
- RAW ordering override: if the EXEC slot holds a write and the IFU slot holds a read to the same address, EXEC wins regardless of rr, and rr is not changed.
- Read return: a registered owner tag (NONE/IFU/EXEC) is set when a read is issued.
  - The cycle after the read mem_req, the owner's *_rd_vld = 1 and its *_rd_data = mem_rdata.
  - Both rd_data ports carry mem_rdata at all times.
- Writes produce no response.
- Protocol errors: proto_err is set and stays set until reset in each of these cases:
  - exec_rd_req and exec_wr_req high in the same cycle. The write is captured and the read is dropped.
  - A request arrives while its slot is PENDING. The new request is dropped and the slot keeps its original contents.
- Capture and release in the same cycle: a slot granted in cycle T is EMPTY in cycle T+1. A request arriving in T+1 is accepted; one arriving in T is rejected as an error.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ifu_rd_vld=0, exec_rd_vld=0, ifu_busy=0, exec_busy=0, proto_err=0, owner=NONE, rr=EXEC.
- Uncontended request pulse in cycle N:
  - Slot PENDING and busy=1 in cycle N+1. That slot is granted in cycle N+1.
  - mem_req=1 in cycle N+2.
  - For a read, mem_rdata is valid and rd_vld=1 in cycle N+3. Read latency is 3 cycles, request pulse to rd_vld.
- A loser under contention issues exactly one cycle after the winner. Worst-case request-to-mem_req delay is 3 cycles.
- Back-to-back issue: mem_req may be high in consecutive cycles. Reads are pipelined; one owner tag per cycle is sufficient because memory latency is exactly 1.
- Reset asserted mid-operation: the next cycle shows every output at its reset value.
  - Pending slots are discarded.
  - A read issued in the reset cycle returns no rd_vld.
- There is no combinational path from request inputs to mem_* outputs.

## Test plan
- Single IFU read, addr 0o200, memory returns 0o7402 → mem_req/mem_we=0/mem_addr=0o200 at N+2; ifu_rd_vld=1, ifu_rd_data=0o7402 at N+3; exec_rd_vld stays 0.
- IFU read 0o100 and EXEC read 0o300 pulsed in the same cycle after reset → EXEC issued at N+2, IFU at N+3. exec_rd_vld at N+3, ifu_rd_vld at N+4. Repeat with both → IFU issued first (rr alternation).
- EXEC write 0o4321 to 0o250 and IFU read of 0o250 in the same cycle, with rr pointing at IFU → write issues first; the IFU read then returns 0o4321 and rr is unchanged.
- exec_rd_req and exec_wr_req pulsed together → only the write appears on mem_*; proto_err=1 until reset_n=0.
- A second ifu_rd_req while ifu_busy=1 → dropped and proto_err=1. A request in the cycle after grant → accepted with no error.
- reset_n driven low in the cycle a read issues → all outputs at reset values the next cycle; no rd_vld pulse afterwards.
